// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the data-memory arbiter:
// instruction codes, status codes and the response-register states.
package y86_pkg;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      RESP_F = 2'd1,
      RESP_D = 2'd2
   } resp_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Fetch and memory-stage request/response bundle for the data-memory arbiter.
// The pipeline side uses the master modport, the arbiter uses slave.
interface dmem_arbiter_if;

   logic        f_req;
   logic [63:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [63:0] f_rdata;
   logic        f_err;

   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [63:0] d_rdata;
   logic        d_err;

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
      input  f_gnt, f_rvalid, f_rdata, f_err,
      input  d_gnt, d_rvalid, d_rdata, d_err
   );

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
      output f_gnt, f_rvalid, f_rdata, f_err,
      output d_gnt, d_rvalid, d_rdata, d_err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x 64 RAM: synchronous write, registered read, and a
// combinational range check on the presented word index.
module dmem_array #(
   parameter int DEPTH = 1024
) (
   input  logic        i_clk,
   input  logic        i_en,
   input  logic        i_we,
   input  logic [63:0] i_addr,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_rdata,
   output logic        o_err
);

   localparam int AW = $clog2(DEPTH);

   logic [63:0]   r_mem [DEPTH];
   logic [63:0]   r_rdata;
   logic          w_inRange;
   logic [AW-1:0] w_idx;

   assign w_inRange = (i_addr < 64'(DEPTH));
   assign w_idx     = i_addr[AW-1:0];
   assign o_err     = !w_inRange;
   assign o_rdata   = r_rdata;

   // Out-of-range accesses never touch the array and read back as zero;
   // a write acknowledges with zero data.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            if (w_inRange) begin
               r_mem[w_idx] <= i_wdata;
            end
            r_rdata <= 64'd0;
         end else begin
            r_rdata <= w_inRange ? r_mem[w_idx] : 64'd0;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the shared data memory between fetch and the memory stage,
// with a starvation counter that eventually forces a fetch grant.
module dmem_arbiter
   import y86_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int MAX_STALL = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   logic        w_fGnt;
   logic        w_dGnt;
   logic        w_anyGnt;
   logic        w_we;
   logic [63:0] w_addr;
   logic [63:0] w_arrRdata;
   logic        w_arrErr;
   resp_state_e w_respNext;

   logic [2:0]  r_stallCnt;
   resp_state_e r_resp;
   logic        r_err;
   logic [63:0] r_fHold;
   logic [63:0] r_dHold;

   // Data wins contention until fetch has waited MAX_STALL cycles.
   always_comb begin
      w_fGnt   = bus.f_req && (!bus.d_req || (r_stallCnt == 3'(MAX_STALL)));
      w_dGnt   = bus.d_req && !w_fGnt;
      w_anyGnt = w_fGnt || w_dGnt;
      w_we     = w_dGnt && bus.d_we;
      w_addr   = w_fGnt ? bus.f_addr : bus.d_addr;
   end

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .i_clk   (clk),
      .i_en    (w_anyGnt),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (bus.d_wdata),
      .o_rdata (w_arrRdata),
      .o_err   (w_arrErr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= 3'd0;
      end else if (w_fGnt) begin
         r_stallCnt <= 3'd0;
      end else if (bus.f_req && (r_stallCnt < 3'(MAX_STALL))) begin
         r_stallCnt <= r_stallCnt + 3'd1;
      end
   end

   always_comb begin
      w_respNext = NONE;
      if (w_fGnt) begin
         w_respNext = RESP_F;
      end else if (w_dGnt) begin
         w_respNext = RESP_D;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp <= NONE;
         r_err  <= 1'b0;
      end else begin
         r_resp <= w_respNext;
         r_err  <= w_anyGnt && w_arrErr;
      end
   end

   // Hold registers keep each port's last read data once its pulse ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fHold <= 64'd0;
         r_dHold <= 64'd0;
      end else begin
         if (r_resp == RESP_F) begin
            r_fHold <= w_arrRdata;
         end
         if (r_resp == RESP_D) begin
            r_dHold <= w_arrRdata;
         end
      end
   end

   assign bus.f_gnt    = w_fGnt;
   assign bus.d_gnt    = w_dGnt;
   assign bus.f_rvalid = (r_resp == RESP_F);
   assign bus.d_rvalid = (r_resp == RESP_D);
   assign bus.f_rdata  = (r_resp == RESP_F) ? w_arrRdata : r_fHold;
   assign bus.d_rdata  = (r_resp == RESP_D) ? w_arrRdata : r_dHold;
   assign bus.f_err    = (r_resp == RESP_F) && r_err;
   assign bus.d_err    = (r_resp == RESP_D) && r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses are queued at grant
// time from a reference memory model and retired by a response monitor.
module tb_dmem_arbiter;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } resp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   resp_t       fq[$];
   resp_t       dq[$];
   logic [63:0] model [0:1023];

   dmem_arbiter_if bus();

   dmem_arbiter #(.DEPTH(1024), .MAX_STALL(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic resp_t expRead(input logic [63:0] a);
      resp_t r;
      if (a < 64'd1024) begin
         r.rdata = model[a[9:0]];
         r.err   = 1'b0;
      end else begin
         r.rdata = 64'd0;
         r.err   = 1'b1;
      end
      return r;
   endfunction

   // Retires one expected response per rvalid pulse, per port.
   always @(negedge clk) begin
      resp_t e;
      if (rst_n === 1'b1) begin
         if (bus.f_rvalid === 1'b1) begin
            checks++;
            if (fq.size() == 0) begin
               errors++;
               $display("[TB] FAIL f_resp_unexpected: got f_rvalid=1, required no response");
            end else begin
               e = fq.pop_front();
               if (bus.f_rdata !== e.rdata || bus.f_err !== e.err) begin
                  errors++;
                  $display("[TB] FAIL f_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                           bus.f_rdata, bus.f_err, e.rdata, e.err);
               end
            end
         end
         if (bus.d_rvalid === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("[TB] FAIL d_resp_unexpected: got d_rvalid=1, required no response");
            end else begin
               e = dq.pop_front();
               if (bus.d_rdata !== e.rdata || bus.d_err !== e.err) begin
                  errors++;
                  $display("[TB] FAIL d_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                           bus.d_rdata, bus.d_err, e.rdata, e.err);
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic fr, input logic [63:0] fa,
                                input logic dr, input logic dw,
                                input logic [63:0] da, input logic [63:0] dd);
      @(negedge clk);
      bus.f_req   = fr;
      bus.f_addr  = fa;
      bus.d_req   = dr;
      bus.d_we    = dw;
      bus.d_addr  = da;
      bus.d_wdata = dd;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b, required 0000",
                  {bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err});
      end
      checks++;
      if (bus.f_rdata !== 64'd0 || bus.d_rdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_rdata: got f=%h d=%h, required 0", bus.f_rdata, bus.d_rdata);
      end
      checks++;
      if ({bus.f_gnt, bus.d_gnt} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_gnt: got %b, required 00", {bus.f_gnt, bus.d_gnt});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'd203, 64'd123);
      checks++;
      if ({bus.f_gnt, bus.d_gnt} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL wr_gnt: got %b, required 01", {bus.f_gnt, bus.d_gnt});
      end
      dq.push_back('{rdata: 64'd0, err: 1'b0});
      model[203] = 64'd123;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd203, 64'd0);
      checks++;
      if ({bus.f_gnt, bus.d_gnt, bus.d_rvalid} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL rd_gnt_ack: got gnt/rvalid=%b, required 011",
                  {bus.f_gnt, bus.d_gnt, bus.d_rvalid});
      end
      dq.push_back(expRead(64'd203));
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 64'd123) begin
         errors++;
         $display("[TB] FAIL rd_203: got rvalid=%b rdata=%h, required 1 and %h",
                  bus.d_rvalid, bus.d_rdata, 64'd123);
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic test_fetch;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'd1023, 64'hDEAD);
      dq.push_back('{rdata: 64'd0, err: 1'b0});
      model[1023] = 64'hDEAD;
      applyStimulus(1'b1, 64'd1023, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if ({bus.f_gnt, bus.d_gnt} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL fetch_gnt: got %b, required 10", {bus.f_gnt, bus.d_gnt});
      end
      fq.push_back(expRead(64'd1023));
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 64'hDEAD || bus.f_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_1023: got rvalid=%b rdata=%h err=%b, required 1 dead 0",
                  bus.f_rvalid, bus.f_rdata, bus.f_err);
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 64'hDEAD) begin
         errors++;
         $display("[TB] FAIL fetch_hold: got rvalid=%b rdata=%h, required 0 dead",
                  bus.f_rvalid, bus.f_rdata);
      end
   endtask

   task automatic test_contention;
      logic expF;
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, 64'd1023, 1'b1, 1'b0, 64'd203, 64'd0);
         expF = (i == 5);
         checks++;
         if (bus.f_gnt !== expF || bus.d_gnt !== !expF) begin
            errors++;
            $display("[TB] FAIL contention_cycle%0d: got f_gnt=%b d_gnt=%b, required %b %b",
                     i, bus.f_gnt, bus.d_gnt, expF, !expF);
         end
         if (expF) fq.push_back(expRead(64'd1023));
         else      dq.push_back(expRead(64'd203));
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic test_range;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'd0, 64'h55);
      dq.push_back('{rdata: 64'd0, err: 1'b0});
      model[0] = 64'h55;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd1024, 64'd0);
      dq.push_back(expRead(64'd1024));
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'h1_0000_0000, 64'd99);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL range_rd1024: got rvalid=%b err=%b rdata=%h, required 1 1 0",
                  bus.d_rvalid, bus.d_err, bus.d_rdata);
      end
      dq.push_back('{rdata: 64'd0, err: 1'b1});
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.d_err !== 1'b1 || bus.d_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL range_wr_hi: got err=%b gnt=%b, required 1 1", bus.d_err, bus.d_gnt);
      end
      dq.push_back(expRead(64'd0));
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic test_back_to_back;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'd5, 64'd7);
      dq.push_back('{rdata: 64'd0, err: 1'b0});
      model[5] = 64'd7;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd5, 64'd0);
      dq.push_back(expRead(64'd5));
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.d_rvalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_ack: got gnt=%b rvalid=%b, required 1 1", bus.d_gnt, bus.d_rvalid);
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 64'd7) begin
         errors++;
         $display("[TB] FAIL b2b_read: got rvalid=%b rdata=%h, required 1 and 7",
                  bus.d_rvalid, bus.d_rdata);
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic test_reset_mid;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd203, 64'd0);
      checks++;
      if (bus.d_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_gnt: got %b, required 1", bus.d_gnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err} !== 4'b0000 ||
          bus.f_rdata !== 64'd0 || bus.d_rdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL midrst_outputs: got flags=%b f=%h d=%h, required all 0",
                  {bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err}, bus.f_rdata, bus.d_rdata);
      end
      rst_n = 1'b1;
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.d_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_dropped: got d_rvalid=%b, required 0", bus.d_rvalid);
      end
      applyStimulus(1'b1, 64'd5, 1'b1, 1'b0, 64'd203, 64'd0);
      dq.push_back(expRead(64'd203));
      applyStimulus(1'b1, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0);
      checks++;
      if (bus.f_gnt !== 1'b1 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== 64'd123) begin
         errors++;
         $display("[TB] FAIL midrst_after: got f_gnt=%b rvalid=%b rdata=%h, required 1 1 7b",
                  bus.f_gnt, bus.d_rvalid, bus.d_rdata);
      end
      fq.push_back(expRead(64'd5));
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fetch();
      test_contention();
      test_range();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (fq.size() != 0 || dq.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_responses: got %0d fetch and %0d data outstanding, required 0 and 0",
                  fq.size(), dq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
